// File: rtl/brisc_pkg.sv
// Shared BRISC decode types: opcodes, function fields and the control bundle
// handed from decode to execute.
package brisc_pkg;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_R      = 7'b0110011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_END    = 7'b1111111;

   localparam logic [6:0] FUNCT7_ZERO = 7'h00;
   localparam logic [6:0] FUNCT7_SUB  = 7'h20;
   localparam logic [6:0] FUNCT7_MUL  = 7'h01;

   localparam logic [2:0] FUNCT3_ADD = 3'b000;
   localparam logic [2:0] FUNCT3_OR  = 3'b110;
   localparam logic [2:0] FUNCT3_AND = 3'b111;
   localparam logic [2:0] FUNCT3_BEQ = 3'b000;
   localparam logic [2:0] FUNCT3_B   = 3'b000;
   localparam logic [2:0] FUNCT3_H   = 3'b001;
   localparam logic [2:0] FUNCT3_W   = 3'b010;

   typedef enum logic [2:0] {I_IMM, S_IMM, B_IMM, U_IMM, J_IMM} imm_src_e;
   typedef enum logic [1:0] {FROM_ALU, FROM_CACHE, FROM_PC_NEXT} result_src_e;
   typedef enum logic       {SRC1_RS1, SRC1_PC} alu_src1_e;
   typedef enum logic       {SRC2_RS2, SRC2_IMM} alu_src2_e;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_MUL, ALU_OR, ALU_AND} alu_ctrl_e;
   typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} data_size_e;
   typedef enum logic       {NO_XCPT, UNDEF_INSTR} xcpt_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        is_branch;
      logic        is_jump;
      imm_src_e    imm_src;
      result_src_e result_src;
      alu_src1_e   alu_src1;
      alu_src2_e   alu_src2;
      alu_ctrl_e   alu_ctrl;
      data_size_e  data_size;
      xcpt_e       xcpt;
   } ctrl_bundle_t;

   // Side-effect-free bundle; also the base for undefined instructions.
   localparam ctrl_bundle_t IDLE_BUNDLE = '{
      reg_write:  1'b0,
      mem_write:  1'b0,
      is_branch:  1'b0,
      is_jump:    1'b0,
      imm_src:    I_IMM,
      result_src: FROM_ALU,
      alu_src1:   SRC1_RS1,
      alu_src2:   SRC2_RS2,
      alu_ctrl:   ALU_ADD,
      data_size:  SIZE_W,
      xcpt:       NO_XCPT
   };

   function automatic logic is_end_op(input logic [6:0] opcode);
      return opcode == OPCODE_END;
   endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational BRISC decoder: opcode/funct3/funct7 to control bundle.
// Anything not explicitly legal collapses to IDLE_BUNDLE with UNDEF_INSTR.
module ctrl_decode_comb
   import brisc_pkg::*;
#(
   parameter int ENABLE_MUL   = 1,
   parameter int SUPPORT_HALF = 0
) (
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [6:0]   funct7,
   output ctrl_bundle_t ctrl
);

   ctrl_bundle_t dec;
   logic         legal;
   data_size_e   mem_size;
   logic         mem_size_ok;

   // LOAD and STORE share the same funct3 size encoding.
   always_comb begin
      mem_size    = SIZE_W;
      mem_size_ok = 1'b0;
      case (funct3)
         FUNCT3_B: begin
            mem_size    = SIZE_B;
            mem_size_ok = 1'b1;
         end
         FUNCT3_H: begin
            mem_size    = SIZE_H;
            mem_size_ok = (SUPPORT_HALF != 0);
         end
         FUNCT3_W: begin
            mem_size    = SIZE_W;
            mem_size_ok = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      dec   = IDLE_BUNDLE;
      legal = 1'b0;
      case (opcode)
         OPCODE_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.imm_src   = U_IMM;
            dec.alu_src1  = SRC1_PC;
            dec.alu_src2  = SRC2_IMM;
            legal         = 1'b1;
         end
         OPCODE_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.alu_src2   = SRC2_IMM;
            dec.result_src = FROM_CACHE;
            dec.data_size  = mem_size;
            legal          = mem_size_ok;
         end
         OPCODE_STORE: begin
            dec.mem_write = 1'b1;
            dec.imm_src   = S_IMM;
            dec.alu_src2  = SRC2_IMM;
            dec.data_size = mem_size;
            legal         = mem_size_ok;
         end
         OPCODE_R: begin
            dec.reg_write = 1'b1;
            if (funct7 == FUNCT7_ZERO) begin
               case (funct3)
                  FUNCT3_ADD: begin dec.alu_ctrl = ALU_ADD; legal = 1'b1; end
                  FUNCT3_OR:  begin dec.alu_ctrl = ALU_OR;  legal = 1'b1; end
                  FUNCT3_AND: begin dec.alu_ctrl = ALU_AND; legal = 1'b1; end
                  default: ;
               endcase
            end else if (funct7 == FUNCT7_SUB && funct3 == FUNCT3_ADD) begin
               dec.alu_ctrl = ALU_SUB;
               legal        = 1'b1;
            end else if (funct7 == FUNCT7_MUL && funct3 == FUNCT3_ADD) begin
               dec.alu_ctrl = ALU_MUL;
               legal        = (ENABLE_MUL != 0);
            end
         end
         OPCODE_IMM: begin
            // Upper bits are immediate here, so funct7 never selects SUB.
            dec.reg_write = 1'b1;
            dec.alu_src2  = SRC2_IMM;
            case (funct3)
               FUNCT3_ADD: begin dec.alu_ctrl = ALU_ADD; legal = 1'b1; end
               FUNCT3_OR:  begin dec.alu_ctrl = ALU_OR;  legal = 1'b1; end
               FUNCT3_AND: begin dec.alu_ctrl = ALU_AND; legal = 1'b1; end
               default: ;
            endcase
         end
         OPCODE_BRANCH: begin
            dec.is_branch = 1'b1;
            dec.imm_src   = B_IMM;
            dec.alu_ctrl  = ALU_SUB;
            legal         = (funct3 == FUNCT3_BEQ);
         end
         OPCODE_JAL: begin
            dec.reg_write  = 1'b1;
            dec.is_jump    = 1'b1;
            dec.imm_src    = J_IMM;
            dec.result_src = FROM_PC_NEXT;
            dec.alu_src1   = SRC1_PC;
            dec.alu_src2   = SRC2_IMM;
            legal          = 1'b1;
         end
         OPCODE_END: legal = 1'b1;
         default: ;
      endcase

      ctrl = dec;
      if (!legal) begin
         ctrl      = IDLE_BUNDLE;
         ctrl.xcpt = UNDEF_INSTR;
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage between fetch and execute: one-entry holding register
// with valid/ready on both sides, MUL structural stall, flush and sticky halt.
module decode_ctrl_pipe
   import brisc_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int MUL_LATENCY  = 5,
   parameter int ENABLE_MUL   = 1,
   parameter int SUPPORT_HALF = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output ctrl_bundle_t          out_ctrl,
   output logic [31:0]           out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  halted
);

   localparam int               CNT_W      = $clog2(MUL_LATENCY + 1);
   localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LATENCY - 1);

   logic                  hold_q, hold_d;
   logic                  out_valid_q, out_valid_d;
   logic                  halted_q, halted_d;
   logic [CNT_W-1:0]      mul_cnt_q, mul_cnt_d;
   ctrl_bundle_t          ctrl_q, ctrl_d;
   logic [31:0]           instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;

   ctrl_bundle_t          dec_ctrl;
   logic                  accept;
   logic                  out_fire;

   ctrl_decode_comb #(
      .ENABLE_MUL   (ENABLE_MUL),
      .SUPPORT_HALF (SUPPORT_HALF)
   ) u_decode (
      .opcode (in_instr[6:0]),
      .funct3 (in_instr[14:12]),
      .funct7 (in_instr[31:25]),
      .ctrl   (dec_ctrl)
   );

   // hold_q tracks occupancy; out_valid_q is occupancy masked by the MUL stall,
   // so a held instruction cannot be overwritten while the stall runs.
   always_comb begin
      in_ready = ~halted_q & ~flush & (~hold_q | (out_valid_q & out_ready));
      accept   = in_valid & in_ready;
      out_fire = out_valid_q & out_ready;

      hold_d    = hold_q;
      halted_d  = halted_q;
      mul_cnt_d = mul_cnt_q;
      ctrl_d    = ctrl_q;
      instr_d   = instr_q;
      pc_d      = pc_q;

      if (mul_cnt_q != '0) begin
         mul_cnt_d = mul_cnt_q - CNT_W'(1);
      end

      if (flush) begin
         hold_d    = 1'b0;
         mul_cnt_d = '0;
         halted_d  = 1'b0;
      end else begin
         if (out_fire) begin
            hold_d = 1'b0;
            if (ctrl_q.alu_ctrl == ALU_MUL) begin
               mul_cnt_d = MUL_RELOAD;
            end
         end
         if (accept) begin
            hold_d  = 1'b1;
            ctrl_d  = dec_ctrl;
            instr_d = in_instr;
            pc_d    = in_pc;
            if (dec_ctrl.xcpt != NO_XCPT || is_end_op(in_instr[6:0])) begin
               halted_d = 1'b1;
            end
         end
      end

      out_valid_d = hold_d & (mul_cnt_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q      <= 1'b0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         mul_cnt_q   <= '0;
         ctrl_q      <= '0;
         instr_q     <= '0;
         pc_q        <= '0;
      end else begin
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
         mul_cnt_q   <= mul_cnt_d;
         ctrl_q      <= ctrl_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ctrl  = ctrl_q;
   assign out_instr = instr_q;
   assign out_pc    = pc_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench: dut 0 uses MUL_LATENCY=5, MUL on, no halfwords;
// dut 1 has MUL off and halfword loads/stores on.
module tb_decode_ctrl_pipe;
   import brisc_pkg::*;

   typedef struct packed {
      ctrl_bundle_t c;
      logic [31:0]  pc;
      logic [31:0]  ins;
   } exp_t;

   logic         clk;
   logic         rst       [2];
   logic         flush     [2];
   logic         in_valid  [2];
   logic         in_ready  [2];
   logic [31:0]  in_instr  [2];
   logic [31:0]  in_pc     [2];
   logic         out_valid [2];
   logic         out_ready [2];
   ctrl_bundle_t out_ctrl  [2];
   logic [31:0]  out_instr [2];
   logic [31:0]  out_pc    [2];
   logic         halted    [2];

   exp_t exp_q [2][$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      exp_t e;

      decode_ctrl_pipe #(
         .ADDR_WIDTH   (32),
         .MUL_LATENCY  (5),
         .ENABLE_MUL   (gi == 0 ? 1 : 0),
         .SUPPORT_HALF (gi == 0 ? 0 : 1)
      ) u_dut (
         .clk       (clk),
         .reset     (rst[gi]),
         .flush     (flush[gi]),
         .in_valid  (in_valid[gi]),
         .in_ready  (in_ready[gi]),
         .in_instr  (in_instr[gi]),
         .in_pc     (in_pc[gi]),
         .out_valid (out_valid[gi]),
         .out_ready (out_ready[gi]),
         .out_ctrl  (out_ctrl[gi]),
         .out_instr (out_instr[gi]),
         .out_pc    (out_pc[gi]),
         .halted    (halted[gi])
      );

      // Monitor: every output handshake must match the oldest accepted instruction.
      always @(negedge clk) begin
         if (!rst[gi] && out_valid[gi] && out_ready[gi]) begin
            if (exp_q[gi].size() == 0) begin
               total_cnt++;
               $display("FAIL dut%0d_unexpected_out: got pc %0h instr %0h expected no output",
                        gi, out_pc[gi], out_instr[gi]);
            end else begin
               e = exp_q[gi].pop_front();
               $display("dut%0d out pc=%08h instr=%08h ctrl=%05h", gi, out_pc[gi], out_instr[gi], out_ctrl[gi]);
               check($sformatf("dut%0d_ctrl_%08h", gi, e.ins), out_ctrl[gi], e.c);
               check($sformatf("dut%0d_pc_%08h", gi, e.ins), out_pc[gi], e.pc);
               check($sformatf("dut%0d_instr_%08h", gi, e.ins), out_instr[gi], e.ins);
            end
         end
      end
   end

   function automatic ctrl_bundle_t mk(input logic rw, input logic mw, input logic br, input logic jp,
                                       input imm_src_e imm, input result_src_e res, input alu_src1_e s1,
                                       input alu_src2_e s2, input alu_ctrl_e alu, input data_size_e ds,
                                       input xcpt_e x);
      ctrl_bundle_t c;
      c.reg_write  = rw;
      c.mem_write  = mw;
      c.is_branch  = br;
      c.is_jump    = jp;
      c.imm_src    = imm;
      c.result_src = res;
      c.alu_src1   = s1;
      c.alu_src2   = s2;
      c.alu_ctrl   = alu;
      c.data_size  = ds;
      c.xcpt       = x;
      return c;
   endfunction

   // Called #1 after a posedge; returns #1 after the accepting posedge.
   task automatic send(input int d, input logic [31:0] ins, input logic [31:0] pc, input ctrl_bundle_t c);
      exp_t e;
      bit   done;
      done        = 1'b0;
      in_valid[d] = 1'b1;
      in_instr[d] = ins;
      in_pc[d]    = pc;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            e.c = c; e.pc = pc; e.ins = ins;
            exp_q[d].push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid[d] = 1'b0;
      if (!done) check($sformatf("dut%0d_accept_timeout_%08h", d, ins), 1'b0, 1'b1);
   endtask

   task automatic do_flush(input int d);
      flush[d] = 1'b1;
      @(posedge clk); #1;
      flush[d] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl_bundle_t c_add, c_sub, c_mul, c_or, c_auipc, c_addi, c_beq, c_jal, c_sw, c_lw, c_undef, c_end, c_lh, c_sh;
      int  n;
      bit  seen, done;

      c_add   = mk(1, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_RS2, ALU_ADD, SIZE_W, NO_XCPT);
      c_sub   = mk(1, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_RS2, ALU_SUB, SIZE_W, NO_XCPT);
      c_mul   = mk(1, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_RS2, ALU_MUL, SIZE_W, NO_XCPT);
      c_or    = mk(1, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_IMM, ALU_OR,  SIZE_W, NO_XCPT);
      c_auipc = mk(1, 0, 0, 0, U_IMM, FROM_ALU,     SRC1_PC,  SRC2_IMM, ALU_ADD, SIZE_W, NO_XCPT);
      c_addi  = mk(1, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_W, NO_XCPT);
      c_beq   = mk(0, 0, 1, 0, B_IMM, FROM_ALU,     SRC1_RS1, SRC2_RS2, ALU_SUB, SIZE_W, NO_XCPT);
      c_jal   = mk(1, 0, 0, 1, J_IMM, FROM_PC_NEXT, SRC1_PC,  SRC2_IMM, ALU_ADD, SIZE_W, NO_XCPT);
      c_sw    = mk(0, 1, 0, 0, S_IMM, FROM_ALU,     SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_W, NO_XCPT);
      c_lw    = mk(1, 0, 0, 0, I_IMM, FROM_CACHE,   SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_W, NO_XCPT);
      c_undef = mk(0, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_RS2, ALU_ADD, SIZE_W, UNDEF_INSTR);
      c_end   = mk(0, 0, 0, 0, I_IMM, FROM_ALU,     SRC1_RS1, SRC2_RS2, ALU_ADD, SIZE_W, NO_XCPT);
      c_lh    = mk(1, 0, 0, 0, I_IMM, FROM_CACHE,   SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_H, NO_XCPT);
      c_sh    = mk(0, 1, 0, 0, S_IMM, FROM_ALU,     SRC1_RS1, SRC2_IMM, ALU_ADD, SIZE_H, NO_XCPT);

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; flush[d] = 1'b0; in_valid[d] = 1'b0;
         in_instr[d] = '0; in_pc[d] = '0; out_ready[d] = 1'b1;
      end
      @(posedge clk); #1;
      check("reset_state", {out_valid[0], halted[0], out_ctrl[0], out_pc[0], out_instr[0]}, 96'h0);
      @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // 1: basic decode, one-cycle latency, back-to-back issue
      send(0, 32'h002081B3, 32'h100, c_add);
      @(negedge clk);
      check("latency_add", out_valid[0], 1'b1);
      @(posedge clk); #1;
      send(0, 32'h402081B3, 32'h104, c_sub);
      send(0, 32'h00001297, 32'h108, c_auipc);
      send(0, 32'h00A08193, 32'h10C, c_addi);
      send(0, 32'h4000E193, 32'h110, c_or);
      send(0, 32'h00208463, 32'h114, c_beq);
      send(0, 32'h008000EF, 32'h118, c_jal);
      send(0, 32'h0050A423, 32'h11C, c_sw);

      // 2: MUL followed immediately by ADD; ADD appears 4 edges after the MUL handshake
      send(0, 32'h022081B3, 32'h200, c_mul);
      send(0, 32'h002081B3, 32'h204, c_add);
      n = 0; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (out_valid[0]) done = 1'b1;
         else begin
            if (i == 0) check("stall_in_ready", in_ready[0], 1'b0);
            n++;
            @(posedge clk); #1;
         end
      end
      check("mul_stall_cycles", n, 4);
      @(posedge clk); #1;

      // 3: backpressure holds LW stable
      out_ready[0] = 1'b0;
      send(0, 32'h0080A283, 32'h300, c_lw);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("hold_stable_%0d", k),
               {out_valid[0], in_ready[0], out_pc[0], out_instr[0], out_ctrl[0]},
               {1'b1, 1'b0, 32'h300, 32'h0080A283, c_lw});
         @(posedge clk); #1;
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;

      // 4: illegal LH halts; further input ignored until flush
      send(0, 32'h00809283, 32'h400, c_undef);
      @(negedge clk);
      check("halt_after_lh", halted[0], 1'b1);
      @(posedge clk); #1;
      in_valid[0] = 1'b1; in_instr[0] = 32'h002081B3; in_pc[0] = 32'h404;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         seen |= in_ready[0];
         @(posedge clk); #1;
      end
      in_valid[0] = 1'b0;
      check("halt_blocks_in_ready", seen, 1'b0);
      flush[0] = 1'b1;
      @(negedge clk);
      check("flush_in_ready_low", in_ready[0], 1'b0);
      @(posedge clk); #1;
      flush[0] = 1'b0;
      @(negedge clk);
      check("flush_clears_halt", {halted[0], in_ready[0]}, 2'b01);
      @(posedge clk); #1;
      send(0, 32'h102081B3, 32'h410, c_undef);
      @(negedge clk);
      check("halt_bad_funct7", halted[0], 1'b1);
      @(posedge clk); #1;
      do_flush(0);
      send(0, 32'h0000007F, 32'h420, c_end);
      @(negedge clk);
      check("halt_after_end", halted[0], 1'b1);
      @(posedge clk); #1;
      do_flush(0);

      // 5: flush at mul_cnt==2 discards the held ADD
      send(0, 32'h022081B3, 32'h500, c_mul);
      send(0, 32'h002081B3, 32'h504, c_add);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mul_cnt_before_flush", g_dut[0].u_dut.mul_cnt_q, 2);
      do_flush(0);
      void'(exp_q[0].pop_back());
      @(negedge clk);
      check("after_flush", {out_valid[0], g_dut[0].u_dut.mul_cnt_q, in_ready[0]}, {1'b0, 3'd0, 1'b1});
      @(posedge clk); #1;
      @(negedge clk);
      check("flushed_stays_empty", out_valid[0], 1'b0);
      @(posedge clk); #1;
      send(0, 32'h0020E1B3, 32'h508, mk(1, 0, 0, 0, I_IMM, FROM_ALU, SRC1_RS1, SRC2_RS2, ALU_OR, SIZE_W, NO_XCPT));
      @(negedge clk);
      check("accept_after_flush", out_valid[0], 1'b1);
      @(posedge clk); #1;

      // 6: asynchronous reset mid-stall and with a bundle presented
      send(0, 32'h022081B3, 32'h600, c_mul);
      send(0, 32'h00809283, 32'h604, c_undef);
      @(posedge clk); #1;
      check("pre_reset_halted", halted[0], 1'b1);
      #2 rst[0] = 1'b1;
      #1;
      check("async_reset_stall",
            {out_valid[0], halted[0], g_dut[0].u_dut.mul_cnt_q, in_ready[0], out_ctrl[0], out_pc[0]},
            {1'b0, 1'b0, 3'd0, 1'b1, 17'h0, 32'h0});
      exp_q[0].delete();
      @(posedge clk); #1;
      rst[0] = 1'b0;
      out_ready[0] = 1'b0;
      send(0, 32'h00A08193, 32'h700, c_addi);
      #2 rst[0] = 1'b1;
      #1;
      check("async_reset_valid", {out_valid[0], out_instr[0]}, 33'h0);
      exp_q[0].delete();
      @(posedge clk); #1;
      rst[0] = 1'b0;
      out_ready[0] = 1'b1;

      // Alternate configuration: MUL disabled, halfword access enabled
      send(1, 32'h022081B3, 32'h800, c_undef);
      @(negedge clk);
      check("alt_mul_halts", halted[1], 1'b1);
      @(posedge clk); #1;
      do_flush(1);
      send(1, 32'h00809283, 32'h804, c_lh);
      send(1, 32'h00509423, 32'h808, c_sh);
      send(1, 32'h002081B3, 32'h80C, c_add);
      @(negedge clk);
      check("alt_no_halt", halted[1], 1'b0);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      #1;
      check("dut0_drained", exp_q[0].size(), 0);
      check("dut1_drained", exp_q[1].size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
